// File: rtl/sc_pkg.sv
// Shared types and LFSR tap tables for the stochastic-computing blocks.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Maximal-length tap mask for a shift-left Fibonacci LFSR.
  // Bit k set means stage k+1 feeds the XOR.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  // Reciprocal polynomial: tap t maps to w-t, and the top stage is always kept.
  function automatic logic [15:0] lfsr_taps_recip(input int w);
    logic [15:0] t;
    logic [15:0] r;
    t = lfsr_taps(w);
    r = 16'h0001 << (w - 1);
    for (int unsigned i = 0; i < 15; i++) begin
      if ((((t >> i) & 16'h0001) != 16'h0000) && (int'(i) < w - 1))
        r = r | (16'h0001 << (w - 2 - int'(i)));
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Shift-left Fibonacci LFSR with synchronous reload to its seed.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = {1'b1, {(WIDTH-1){1'b0}}},
  parameter logic [WIDTH-1:0]   SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  // Reload has priority over stepping so a new frame always starts at the seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= SEED;
    else if (load)
      state <= SEED;
    else if (en)
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
  end

endmodule

// File: rtl/sc_robert_sng.sv
// Four-channel stochastic number generator plus 0.5 select stream for the
// Roberts-cross stage. One 2x2 window in, one full-period frame out.
module sc_robert_sng
  import sc_pkg::*;
#(
  parameter int          WIDTH  = 8,
  parameter logic [15:0] SEED_A = 16'h0001,
  parameter logic [15:0] SEED_B = 16'h005A
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] p00,
  input  logic [WIDTH-1:0] p01,
  input  logic [WIDTH-1:0] p10,
  input  logic [WIDTH-1:0] p11,
  output logic             ready,
  output logic             valid,
  output logic             r00,
  output logic             r01,
  output logic             r10,
  output logic             r11,
  output logic             sel,
  output logic             done
);

  localparam logic [15:0]      TAPS_A_F = lfsr_taps(WIDTH);
  localparam logic [15:0]      TAPS_B_F = lfsr_taps_recip(WIDTH);
  localparam logic [WIDTH-1:0] TAPS_A   = TAPS_A_F[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_B   = TAPS_B_F[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_A_W = SEED_A[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_B_W = SEED_B[WIDTH-1:0];
  // Last count of a frame is L-1 = 2^WIDTH - 2.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("sc_robert_sng: WIDTH must be 4..16");
  end
  if (SEED_A_W == '0) begin : g_bad_seed_a
    $error("sc_robert_sng: SEED_A must be nonzero");
  end
  if (SEED_B_W == '0) begin : g_bad_seed_b
    $error("sc_robert_sng: SEED_B must be nonzero");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] p00_q;
  logic [WIDTH-1:0] p01_q;
  logic [WIDTH-1:0] p10_q;
  logic [WIDTH-1:0] p11_q;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic             accept;
  logic             running;

  assign accept  = (state_q == IDLE) && start;
  assign running = (state_q == RUN);

  sc_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS_A),
    .SEED  (SEED_A_W)
  ) u_lfsr_a (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (running),
    .state (lfsr_a)
  );

  sc_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS_B),
    .SEED  (SEED_B_W)
  ) u_lfsr_b (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (running),
    .state (lfsr_b)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: a frame runs exactly L cycles, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel capture and frame counter; the counter saturates at L-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      p00_q <= '0;
      p01_q <= '0;
      p10_q <= '0;
      p11_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      p00_q <= p00;
      p01_q <= p01;
      p10_q <= p10;
      p11_q <= p11;
    end else if (running && (cnt_q != CNT_LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    done  = 1'b0;
    r00   = 1'b0;
    r01   = 1'b0;
    r10   = 1'b0;
    r11   = 1'b0;
    sel   = 1'b0;
    unique case (state_q)
      IDLE: ready = 1'b1;
      RUN: begin
        valid = 1'b1;
        r00   = (lfsr_a <= p00_q);
        r01   = (lfsr_a <= p01_q);
        r10   = (lfsr_a <= p10_q);
        r11   = (lfsr_a <= p11_q);
        sel   = lfsr_b[WIDTH-1];
      end
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sc_robert_sng.sv
// Randomized self-checking bench for sc_robert_sng at WIDTH=8 and WIDTH=4.
module tb_sc_robert_sng;

  localparam int L8 = 255;
  localparam int L4 = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, ready8, valid8, done8, sel8, r00_8, r01_8, r10_8, r11_8;
  logic [7:0] a8, b8, c8, d8;
  logic       start4, ready4, valid4, done4, sel4, r00_4, r01_4, r10_4, r11_4;
  logic [3:0] a4, b4, c4, d4;

  sc_robert_sng #(.WIDTH(8), .SEED_A(16'h0001), .SEED_B(16'h005A)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .p00(a8), .p01(b8), .p10(c8), .p11(d8),
    .ready(ready8), .valid(valid8),
    .r00(r00_8), .r01(r01_8), .r10(r10_8), .r11(r11_8),
    .sel(sel8), .done(done8)
  );

  sc_robert_sng #(.WIDTH(4), .SEED_A(16'h0001), .SEED_B(16'h005A)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .p00(a4), .p01(b4), .p10(c4), .p11(d4),
    .ready(ready4), .valid(valid4),
    .r00(r00_4), .r01(r01_4), .r10(r10_4), .r11(r11_4),
    .sel(sel4), .done(done4)
  );

  int total;
  int bad;

  // rows: 0..3 r00..r11, 4 sel, 5 valid, 6 ready, 7 done
  bit smp [0:7][0:1023];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int ones(input int row, input int lo, input int hi);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) n += int'(smp[row][k]);
    return n;
  endfunction

  // Sample k is taken after the k-th rising edge; the first edge accepts start.
  task automatic run(input int which, input int ncyc, input bit hold, input bit poke);
    int w;
    w = 0;
    while (((which == 1) ? ready4 : ready8) != 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("ready_wait", 0, 1);
    if (which == 1) start4 = 1'b1; else start8 = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        start4 = 1'b0;
        start8 = 1'b0;
        if (poke && (k == 5 || k == 100)) start8 = 1'b1;
      end
      if (poke) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      end
      @(negedge clk);
      if (which == 1) begin
        smp[0][k] = r00_4; smp[1][k] = r01_4; smp[2][k] = r10_4; smp[3][k] = r11_4;
        smp[4][k] = sel4;  smp[5][k] = valid4; smp[6][k] = ready4; smp[7][k] = done4;
      end else begin
        smp[0][k] = r00_8; smp[1][k] = r01_8; smp[2][k] = r10_8; smp[3][k] = r11_8;
        smp[4][k] = sel8;  smp[5][k] = valid8; smp[6][k] = ready8; smp[7][k] = done8;
      end
    end
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Reference: a frame of length L carries exactly p ones per channel,
  // 2^(W-1) sel ones, and its first bit compares against the seed value 1.
  task automatic check_frame(input string tag, input int L, input int base,
                             input int q0, input int q1, input int q2, input int q3,
                             input int sel_ones, input int sel_first);
    int pv[4];
    pv[0] = q0; pv[1] = q1; pv[2] = q2; pv[3] = q3;
    chk({tag, "_valid_len"}, ones(5, base + 1, base + L), L);
    chk({tag, "_busy"}, ones(6, base + 1, base + L + 1), 0);
    chk({tag, "_done_early"}, ones(7, base + 1, base + L), 0);
    chk({tag, "_done"}, int'(smp[7][base + L + 1]), 1);
    chk({tag, "_ready_back"}, int'(smp[6][base + L + 2]), 1);
    chk({tag, "_done_outs"}, ones(0, base + L + 1, base + L + 1) + ones(1, base + L + 1, base + L + 1)
        + ones(2, base + L + 1, base + L + 1) + ones(3, base + L + 1, base + L + 1)
        + ones(4, base + L + 1, base + L + 1) + ones(5, base + L + 1, base + L + 1), 0);
    for (int ch = 0; ch < 4; ch++) begin
      chk($sformatf("%s_ones%0d", tag, ch), ones(ch, base + 1, base + L), pv[ch]);
      chk($sformatf("%s_first%0d", tag, ch), int'(smp[ch][base + 1]), (pv[ch] >= 1) ? 1 : 0);
    end
    chk({tag, "_sel_ones"}, ones(4, base + 1, base + L), sel_ones);
    chk({tag, "_sel_first"}, int'(smp[4][base + 1]), sel_first);
  endtask

  initial begin
    int q[4];
    int a_and, mism, gap, ndone, nready;
    bit found;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; c8 = '0; d8 = '0;
    a4 = '0; b4 = '0; c4 = '0; d4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready8", int'(ready8), 1);
    chk("rst_outs8", int'({valid8, done8, r00_8, r01_8, r10_8, r11_8, sel8}), 0);
    chk("rst_ready4", int'(ready4), 1);
    chk("rst_outs4", int'({valid4, done4, r00_4, r01_4, r10_4, r11_4, sel4}), 0);
    reset = 1'b1;
    @(negedge clk);

    // Exact encoding with extreme and mid values.
    a8 = 8'd0; b8 = 8'd255; c8 = 8'd128; d8 = 8'd37;
    run(0, L8 + 2, 1'b0, 1'b0);
    check_frame("enc", L8, 0, 0, 255, 128, 37, 128, 0);

    // Starts during RUN are ignored; pixel inputs churn after capture.
    for (int i = 0; i < 4; i++) q[i] = int'($urandom_range(0, 255));
    a8 = 8'(q[0]); b8 = 8'(q[1]); c8 = 8'(q[2]); d8 = 8'(q[3]);
    run(0, L8 + 4, 1'b0, 1'b1);
    check_frame("hs", L8, 0, q[0], q[1], q[2], q[3], 128, 0);
    chk("hs_no_queue", ones(5, L8 + 2, L8 + 4), 0);

    // Random windows.
    for (int unsigned it = 0; it < 3; it++) begin
      for (int i = 0; i < 4; i++) q[i] = int'($urandom_range(0, 255));
      a8 = 8'(q[0]); b8 = 8'(q[1]); c8 = 8'(q[2]); d8 = 8'(q[3]);
      run(0, L8 + 2, 1'b0, 1'b0);
      check_frame($sformatf("rnd%0d", it), L8, 0, q[0], q[1], q[2], q[3], 128, 0);
    end

    // Back-to-back frames, same window, start held high.
    for (int i = 0; i < 4; i++) q[i] = int'($urandom_range(1, 254));
    a8 = 8'(q[0]); b8 = 8'(q[1]); c8 = 8'(q[2]); d8 = 8'(q[3]);
    run(0, 2 * L8 + 4, 1'b1, 1'b0);
    check_frame("b2b0", L8, 0, q[0], q[1], q[2], q[3], 128, 0);
    check_frame("b2b1", L8, L8 + 2, q[0], q[1], q[2], q[3], 128, 0);
    found = 1'b0;
    gap = -1;
    for (int k = L8 + 1; k <= 2 * L8 + 4; k++) begin
      if (!found && smp[5][k]) begin
        found = 1'b1;
        gap = k - L8 - 1;
      end
    end
    chk("b2b_gap", gap, 2);
    mism = 0;
    for (int k = 1; k <= L8; k++)
      for (int row = 0; row < 5; row++)
        if (smp[row][k] != smp[row][k + L8 + 2]) mism++;
    chk("b2b_identical", mism, 0);

    // Independence of sel from the pixel streams.
    q[0] = 128; q[1] = int'($urandom_range(0, 255)); q[2] = int'($urandom_range(0, 255)); q[3] = 128;
    a8 = 8'(q[0]); b8 = 8'(q[1]); c8 = 8'(q[2]); d8 = 8'(q[3]);
    run(0, L8 + 2, 1'b0, 1'b0);
    check_frame("ind", L8, 0, q[0], q[1], q[2], q[3], 128, 0);
    a_and = 0;
    mism  = 0;
    for (int k = 1; k <= L8; k++) begin
      a_and += int'(smp[0][k] & smp[4][k]);
      if (smp[0][k] != smp[3][k]) mism++;
    end
    chk("ind_and_window", (a_and >= 56 && a_and <= 72) ? 1 : 0, 1);
    chk("ind_r00_eq_r11", mism, 0);

    // Reset in the middle of a frame.
    a8 = 8'd200; b8 = 8'd10; c8 = 8'd255; d8 = 8'd77;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (40) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", int'(ready8), 1);
    chk("midrst_outs", int'({valid8, done8, r00_8, r01_8, r10_8, r11_8, sel8}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ndone  = 0;
    nready = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      ndone  += int'(done8);
      nready += int'(ready8);
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_idle", nready, 300);

    // WIDTH=4 instance.
    q[0] = 9; q[1] = 0; q[2] = 15; q[3] = int'($urandom_range(0, 15));
    a4 = 4'(q[0]); b4 = 4'(q[1]); c4 = 4'(q[2]); d4 = 4'(q[3]);
    run(1, L4 + 2, 1'b0, 1'b0);
    check_frame("w4", L4, 0, q[0], q[1], q[2], q[3], 8, 1);
    for (int i = 0; i < 4; i++) q[i] = int'($urandom_range(0, 15));
    a4 = 4'(q[0]); b4 = 4'(q[1]); c4 = 4'(q[2]); d4 = 4'(q[3]);
    run(1, L4 + 2, 1'b0, 1'b0);
    check_frame("w4rnd", L4, 0, q[0], q[1], q[2], q[3], 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
